// File: rtl/mc_bus_if_if.sv
// Bus bundle between the MCU-side pins / register fabric and mc_bus_if.
// The slave modport is the view taken by mc_bus_if itself.
interface mc_bus_if_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic          mc_ce;
  logic          mc_oe;
  logic          mc_we;
  logic [AW-1:0] mc_add;
  logic [DW-1:0] mc_data_in;
  logic [DW-1:0] mc_data_out;
  logic          mc_data_oe;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          fifo_push;
  logic [DW-1:0] fifo_data;
  logic          fifo_full;
  logic          rd_strobe;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          overrun;
  logic          proto_err;
  logic          err_clr;

  modport slave (
    input  mc_ce, mc_oe, mc_we, mc_add, mc_data_in, fifo_full, rd_data, err_clr,
    output mc_data_out, mc_data_oe, wr_strobe, wr_addr, wr_data,
           fifo_push, fifo_data, rd_strobe, rd_addr, overrun, proto_err
  );

  modport master (
    output mc_ce, mc_oe, mc_we, mc_add, mc_data_in, fifo_full, rd_data, err_clr,
    input  mc_data_out, mc_data_oe, wr_strobe, wr_addr, wr_data,
           fifo_push, fifo_data, rd_strobe, rd_addr, overrun, proto_err
  );
endinterface

// File: rtl/mc_bus_if.sv
// MCU asynchronous parallel bus slave: synchronises strobes, turns writes into
// register strobes / FIFO pushes and reads into a request plus held read data.
module mc_bus_if #(
  parameter int                      MC_DATA_WIDTH = 16,
  parameter int                      MC_ADD_WIDTH  = 6,
  parameter int                      SYNC_STAGES   = 2,
  parameter logic [MC_ADD_WIDTH-1:0] FIFO_ADDR     = '0
) (
  input  logic        clk,
  input  logic        rst,
  mc_bus_if_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] WR_WAIT = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_CAP  = 3'd4;
  localparam logic [2:0] RD_HOLD = 3'd5;

  // Strobe channels: bit 0 = we, bit 1 = oe, bit 2 = ce
  logic [2:0] pin_raw;
  logic [2:0] synced;
  assign pin_raw = {bus.mc_ce, bus.mc_oe, bus.mc_we};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pin_raw[gi]};
      end
      assign synced[gi] = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic we_s, oe_s, ce_s;
  assign we_s = synced[0];
  assign oe_s = synced[1];
  assign ce_s = synced[2];

  logic [1:0]               prev_q, prev_d;
  logic [SYNC_STAGES-1:0]   fill_q, fill_d;
  logic                     armed_q, armed_d;
  logic [2:0]               state_q, state_d;
  logic [MC_ADD_WIDTH-1:0]  addr_q, addr_d;
  logic [MC_DATA_WIDTH-1:0] data_q, data_d;
  logic [MC_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                     oe_q, oe_d;
  logic                     overrun_q, overrun_d;
  logic                     proto_q, proto_d;
  logic                     we_fall, oe_fall, is_fifo, ovr_set, proto_set;

  // fill_q marks when the synchronisers hold real pin samples, so the
  // reset-value ones never count as "strobe seen high" for arming.
  assign we_fall = armed_q & prev_q[0] & ~we_s;
  assign oe_fall = armed_q & prev_q[1] & ~oe_s;
  assign is_fifo = (addr_q == FIFO_ADDR);

  always_comb begin
    prev_d    = {oe_s, we_s};
    fill_d    = {fill_q[SYNC_STAGES-2:0], 1'b1};
    armed_d   = armed_q | (fill_q[SYNC_STAGES-1] & we_s & oe_s);
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rdata_d   = rdata_q;
    oe_d      = oe_q;
    ovr_set   = 1'b0;
    proto_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ce_s) begin
          if (we_fall) begin
            addr_d    = bus.mc_add;
            data_d    = bus.mc_data_in;
            proto_set = ~oe_s;
            state_d   = WR;
          end else if (oe_fall && we_s) begin
            addr_d  = bus.mc_add;
            state_d = RD_REQ;
          end
        end
      end
      WR: begin
        ovr_set = is_fifo & bus.fifo_full;
        state_d = WR_WAIT;
      end
      WR_WAIT: if (we_s) state_d = IDLE;
      RD_REQ:  state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = bus.rd_data;
        oe_d    = 1'b1;
        state_d = RD_HOLD;
      end
      RD_HOLD: begin
        proto_set = we_fall;
        if (oe_s) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A set event in the same cycle as err_clr keeps the flag set
    overrun_d = ovr_set | (overrun_q & ~bus.err_clr);
    proto_d   = proto_set | (proto_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '1;
      fill_q    <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
      oe_q      <= 1'b0;
      overrun_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
      oe_q      <= oe_d;
      overrun_q <= overrun_d;
      proto_q   <= proto_d;
    end
  end

  assign bus.wr_strobe   = (state_q == WR) & ~is_fifo;
  assign bus.fifo_push   = (state_q == WR) & is_fifo & ~bus.fifo_full;
  assign bus.rd_strobe   = (state_q == RD_REQ);
  assign bus.wr_addr     = addr_q;
  assign bus.wr_data     = data_q;
  assign bus.fifo_data   = data_q;
  assign bus.rd_addr     = addr_q;
  assign bus.mc_data_out = rdata_q;
  assign bus.mc_data_oe  = oe_q;
  assign bus.overrun     = overrun_q;
  assign bus.proto_err   = proto_q;

endmodule

// File: tb/tb_mc_bus_if.sv
// Directed bench for mc_bus_if: writes, FIFO pushes/overrun, reads, chip
// select, protocol error and reset during a held read.
module tb_mc_bus_if;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mc_bus_if_if #(.DW(16), .AW(6)) bus ();

  mc_bus_if #(
    .MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6), .SYNC_STAGES(2), .FIFO_ADDR(6'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [5:0]  wr_a[$];
  logic [15:0] wr_d[$];
  int          wr_c[$];
  logic [15:0] push_d[$];
  logic [5:0]  rd_a[$];
  int          rd_c[$];
  int          oe_rise = -1;
  logic        oe_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      wr_a.push_back(bus.wr_addr);
      wr_d.push_back(bus.wr_data);
      wr_c.push_back(cyc);
    end
    if (bus.fifo_push) push_d.push_back(bus.fifo_data);
    if (bus.rd_strobe) begin
      rd_a.push_back(bus.rd_addr);
      rd_c.push_back(cyc);
    end
    if (bus.mc_data_oe && !oe_prev) oe_rise = cyc;
    oe_prev = bus.mc_data_oe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    push_d.delete(); rd_a.delete(); rd_c.delete();
  endtask

  // Address/data set up 4 clocks before mc_we falls; returns the cycle at drive time
  task automatic mcu_write(input logic [5:0] a, input logic [15:0] d, input int low,
                           input bit with_oe, output int t_low);
    bus.mc_add     = a;
    bus.mc_data_in = d;
    repeat (4) @(negedge clk);
    bus.mc_we = 1'b0;
    if (with_oe) bus.mc_oe = 1'b0;
    t_low = cyc;
    repeat (low) @(negedge clk);
    bus.mc_we = 1'b1;
    bus.mc_oe = 1'b1;
    repeat (6) @(negedge clk);
    $display("write addr=%02h data=%04h low=%0d oe=%0d", a, d, low, with_oe);
  endtask

  int t, m, ok;
  logic [15:0] fifo_vals [4];

  initial begin
    fifo_vals[0] = 16'h0055; fifo_vals[1] = 16'h0020;
    fifo_vals[2] = 16'h0002; fifo_vals[3] = 16'h0303;
    bus.mc_ce = 1'b0; bus.mc_oe = 1'b1; bus.mc_we = 1'b1;
    bus.mc_add = '0; bus.mc_data_in = '0; bus.fifo_full = 1'b0;
    bus.rd_data = '0; bus.err_clr = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_data_oe", bus.mc_data_oe, 0);
    check("rst_data_out", bus.mc_data_out, 0);
    check("rst_wr_strobe", bus.wr_strobe, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_proto_err", bus.proto_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    clear_logs();

    // Single register write, long pulse
    mcu_write(6'h19, 16'h0003, 6, 1'b0, t);
    check("wr_count", wr_a.size(), 1);
    if (wr_a.size() > 0) begin
      check("wr_addr", wr_a[0], 6'h19);
      check("wr_data", wr_d[0], 16'h0003);
      check("wr_latency", wr_c[0], t + 3);
    end
    check("wr_no_push", push_d.size(), 0);
    clear_logs();

    // Four FIFO writes
    for (int i = 0; i < 4; i++) mcu_write(6'h00, fifo_vals[i], 3, 1'b0, t);
    check("fifo_count", push_d.size(), 4);
    for (int i = 0; i < 4 && i < push_d.size(); i++) check("fifo_val", push_d[i], fifo_vals[i]);
    check("fifo_no_wr", wr_a.size(), 0);
    check("fifo_no_overrun", bus.overrun, 0);
    clear_logs();

    // Same, FIFO full during the third
    for (int i = 0; i < 4; i++) begin
      bus.fifo_full = (i == 2);
      mcu_write(6'h00, fifo_vals[i], 3, 1'b0, t);
    end
    bus.fifo_full = 1'b0;
    check("ovr_count", push_d.size(), 3);
    if (push_d.size() == 3) begin
      check("ovr_val0", push_d[0], 16'h0055);
      check("ovr_val1", push_d[1], 16'h0020);
      check("ovr_val2", push_d[2], 16'h0303);
    end
    check("ovr_flag", bus.overrun, 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
    check("ovr_cleared", bus.overrun, 0);
    clear_logs();

    // Read of address 00
    bus.mc_add = 6'h00;
    bus.rd_data = 16'h1234;
    oe_rise = -1;
    repeat (4) @(negedge clk);
    bus.mc_oe = 1'b0;
    t = cyc;
    repeat (6) @(negedge clk);
    bus.rd_data = 16'hBEEF;
    check("rd_count", rd_a.size(), 1);
    if (rd_a.size() > 0) begin
      check("rd_addr", rd_a[0], 6'h00);
      check("rd_latency", rd_c[0], t + 3);
    end
    check("rd_oe_rise", oe_rise, t + 5);
    check("rd_data_out", bus.mc_data_out, 16'h1234);
    bus.mc_oe = 1'b1;
    m = cyc;
    @(negedge clk);
    check("rd_hold1", bus.mc_data_oe, 1);
    @(negedge clk);
    check("rd_hold2", bus.mc_data_oe, 1);
    check("rd_hold_data", bus.mc_data_out, 16'h1234);
    @(negedge clk);
    check("rd_release", bus.mc_data_oe, 0);
    check("rd_release_cyc", cyc, m + 3);
    check("rd_no_wr", wr_a.size(), 0);
    $display("read addr=00 data=%04h", bus.mc_data_out);
    repeat (4) @(negedge clk);
    clear_logs();

    // Chip enable high: nothing happens
    bus.mc_ce = 1'b1;
    mcu_write(6'h05, 16'h1111, 3, 1'b0, t);
    check("ce_no_wr", wr_a.size(), 0);
    check("ce_no_push", push_d.size(), 0);
    check("ce_no_rd", rd_a.size(), 0);
    bus.mc_ce = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();

    // we and oe low together
    mcu_write(6'h07, 16'h00AA, 3, 1'b1, t);
    check("both_wr_count", wr_a.size(), 1);
    if (wr_a.size() > 0) check("both_wr_data", wr_d[0], 16'h00AA);
    check("both_no_rd", rd_a.size(), 0);
    check("both_proto", bus.proto_err, 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
    check("proto_cleared", bus.proto_err, 0);
    clear_logs();

    // Reset while holding read data
    bus.mc_add = 6'h2A;
    bus.mc_data_in = 16'h5A5A;
    bus.rd_data = 16'h0ABC;
    repeat (4) @(negedge clk);
    bus.mc_oe = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mc_data_oe) begin
        ok = 1;
        break;
      end
    end
    check("rh_oe_high", ok, 1);
    rst = 1'b1;
    bus.mc_we = 1'b0;
    bus.mc_oe = 1'b1;
    #1;
    check("rh_oe_drop", bus.mc_data_oe, 0);
    check("rh_data_clr", bus.mc_data_out, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    check("rh_no_wr", wr_a.size(), 0);
    check("rh_no_push", push_d.size(), 0);
    check("rh_no_rd", rd_a.size(), 0);
    bus.mc_we = 1'b1;
    repeat (5) @(negedge clk);
    bus.mc_we = 1'b0;
    repeat (3) @(negedge clk);
    bus.mc_we = 1'b1;
    repeat (6) @(negedge clk);
    check("rh_wr_count", wr_a.size(), 1);
    if (wr_a.size() > 0) begin
      check("rh_wr_addr", wr_a[0], 6'h2A);
      check("rh_wr_data", wr_d[0], 16'h5A5A);
    end
    $display("write after reset addr=2a data=5a5a");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
